cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) among NUM_SRC execution units (ALU, LSU, branch).

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_arbiter_rr.sv | 35 +++
 rtl/cdb_arbiter.sv | 98 +++++++++
 tb/tb_cdb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared out-of-order core types used by the CDB arbiter: result packet layout and source ids.
package cdb_arbiter_pkg;

    localparam int PHYS_REG_BITS = 6;
    localparam int ROB_TAG_BITS  = 5;
    localparam int DATA_W        = 32;
    localparam int NUM_CDB_SRC   = 3;

    typedef struct packed {
        logic [PHYS_REG_BITS-1:0] prd;
        logic [DATA_W-1:0]        data;
        logic [ROB_TAG_BITS-1:0]  rob_tag;
        logic                     reg_write;
    } cdb_pkt_t;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_BR  = 2'd2
    } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    always_comb begin : search
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per execution unit, round-robin grant,
// registered broadcast stage feeding wakeup, PRF write and ROB completion.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = NUM_CDB_SRC,
    localparam int SRC_W  = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_SRC-1:0]       req_valid,
    output logic [NUM_SRC-1:0]       req_ready,
    input  cdb_pkt_t [NUM_SRC-1:0]   req_pkt,
    output logic                     cdb_valid,
    output cdb_pkt_t                 cdb_pkt,
    output logic [SRC_W-1:0]         cdb_src
);

    logic [NUM_SRC-1:0]     hold_valid_q, hold_valid_d;
    cdb_pkt_t [NUM_SRC-1:0] hold_pkt_q, hold_pkt_d;
    logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   cdb_valid_q, cdb_valid_d;
    cdb_pkt_t               cdb_pkt_q, cdb_pkt_d;
    logic [SRC_W-1:0]       cdb_src_q, cdb_src_d;

    logic [NUM_SRC-1:0] arb_req;
    logic [NUM_SRC-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               block;

    // Handshake: a unit's packet transfers at the edge where req_valid[i] && req_ready[i].
    // req_ready never looks at req_valid; a full holder frees itself in the cycle it wins.
    assign block     = flush | rst;
    assign arb_req   = hold_valid_q & {NUM_SRC{~block}};
    assign req_ready = {NUM_SRC{~block}} & (~hold_valid_q | grant);

    rr_arbiter #(.N(NUM_SRC), .IW(SRC_W)) u_rr (
        .req         (arb_req),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_pkt_d   = hold_pkt_q;
        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = 1'b0;
        cdb_pkt_d    = cdb_pkt_q;
        cdb_src_d    = cdb_src_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_pkt_d[i]   = req_pkt[i];
            end else if (grant[i]) begin
                hold_valid_d[i] = 1'b0;
            end
        end
        if (flush) begin
            hold_valid_d = '0;
        end
        if (grant_valid) begin
            cdb_valid_d = 1'b1;
            cdb_pkt_d   = hold_pkt_q[grant_idx];
            cdb_src_d   = grant_idx;
            rr_ptr_d    = (grant_idx == SRC_W'(NUM_SRC-1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= '0;
            hold_pkt_q   <= '0;
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_pkt_q    <= '0;
            cdb_src_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_pkt_q   <= hold_pkt_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_pkt_q    <= cdb_pkt_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_pkt   = cdb_pkt_q;
    assign cdb_src   = cdb_src_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_held:   assert property (@(posedge clk) disable iff (rst) (grant & ~hold_valid_q) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single source, round-robin order, backpressure,
// flush and single-source streaming, with hand-derived per-cycle expectations.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int PKT_W = $bits(cdb_pkt_t);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    cdb_pkt_t [2:0]   req_pkt;
    logic             cdb_valid;
    cdb_pkt_t         cdb_pkt;
    logic [1:0]       cdb_src;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PKT_W-1:0] exp_q[$];

    cdb_arbiter #(.NUM_SRC(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pkt   (req_pkt),
        .cdb_valid (cdb_valid),
        .cdb_pkt   (cdb_pkt),
        .cdb_src   (cdb_src)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog expired");
    end

    // Distinct, recognisable packet per id; even ids carry reg_write=0.
    function automatic cdb_pkt_t pk(int id);
        cdb_pkt_t p;
        p.prd       = PHYS_REG_BITS'(id);
        p.data      = 32'hC0DE_0000 | 32'(id);
        p.rob_tag   = ROB_TAG_BITS'(id);
        p.reg_write = id[0];
        return p;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: apply one cycle of inputs, check that cycle's outputs, advance one clock.
    task automatic cyc(string tag, bit fl, logic [2:0] v, int i0, int i1, int i2,
                       logic [2:0] e_ready, bit e_cv, int e_src, int e_id);
        flush      = fl;
        req_valid  = v;
        req_pkt[0] = pk(i0);
        req_pkt[1] = pk(i1);
        req_pkt[2] = pk(i2);
        #1;
        check({tag, ".ready"}, 64'(req_ready), 64'(e_ready));
        check({tag, ".cdb_valid"}, 64'(cdb_valid), 64'(e_cv));
        if (e_cv) begin
            check({tag, ".cdb_src"}, 64'(cdb_src), 64'(e_src));
            check({tag, ".cdb_pkt"}, 64'(cdb_pkt), 64'(pk(e_id)));
        end
        tick();
    endtask

    initial begin
        cdb_pkt_t t2_pkt;
        logic [PKT_W-1:0] exp_pkt;

        // 1: reset held two edges with all units requesting
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 3'b111;
        req_pkt[0] = pk(1);
        req_pkt[1] = pk(2);
        req_pkt[2] = pk(3);
        tick();
        #1;
        check("t1_rst0.ready", 64'(req_ready), 64'(3'b000));
        check("t1_rst0.cdb_valid", 64'(cdb_valid), 64'(1'b0));
        check("t1_rst0.cdb_src", 64'(cdb_src), 64'(2'd0));
        check("t1_rst0.cdb_pkt", 64'(cdb_pkt), 64'(0));
        tick();
        #1;
        check("t1_rst1.ready", 64'(req_ready), 64'(3'b000));
        check("t1_rst1.cdb_valid", 64'(cdb_valid), 64'(1'b0));
        rst       = 1'b0;
        req_valid = 3'b000;
        tick();
        cyc("t1_after", 0, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0);

        // 2: single ALU packet, two cycles to the CDB
        t2_pkt.prd       = PHYS_REG_BITS'(5);
        t2_pkt.data      = 32'hDEAD;
        t2_pkt.rob_tag   = ROB_TAG_BITS'(2);
        t2_pkt.reg_write = 1'b1;
        req_valid  = 3'b001;
        req_pkt[0] = t2_pkt;
        #1;
        check("t2_c0.ready", 64'(req_ready), 64'(3'b111));
        check("t2_c0.cdb_valid", 64'(cdb_valid), 64'(1'b0));
        tick();
        req_valid = 3'b000;
        #1;
        check("t2_c1.cdb_valid", 64'(cdb_valid), 64'(1'b0));
        tick();
        #1;
        check("t2_c2.cdb_valid", 64'(cdb_valid), 64'(1'b1));
        check("t2_c2.cdb_pkt", 64'(cdb_pkt), 64'(t2_pkt));
        check("t2_c2.cdb_src", 64'(cdb_src), 64'(SRC_ALU));
        tick();
        #1;
        check("t2_c3.cdb_valid", 64'(cdb_valid), 64'(1'b0));
        tick();
        #1;
        check("t2_c4.cdb_valid", 64'(cdb_valid), 64'(1'b0));
        tick();

        // 3: contention; a lone BR grant first returns the pointer to 0
        cyc("t3_b0", 0, 3'b100, 0, 0, 7,  3'b111, 0, 0, 0);
        cyc("t3_b1", 0, 3'b000, 0, 0, 0,  3'b111, 0, 0, 0);
        cyc("t3_b2", 0, 3'b000, 0, 0, 0,  3'b111, 1, 2, 7);
        cyc("t3_c0", 0, 3'b111, 21, 22, 23, 3'b111, 0, 0, 0);
        cyc("t3_c1", 0, 3'b000, 0, 0, 0,  3'b001, 0, 0, 0);
        cyc("t3_c2", 0, 3'b000, 0, 0, 0,  3'b011, 1, 0, 21);
        cyc("t3_c3", 0, 3'b000, 0, 0, 0,  3'b111, 1, 1, 22);
        cyc("t3_c4", 0, 3'b001, 24, 0, 0, 3'b111, 1, 2, 23);
        cyc("t3_c5", 0, 3'b000, 0, 0, 0,  3'b111, 0, 0, 0);
        cyc("t3_c6", 0, 3'b111, 25, 26, 27, 3'b111, 1, 0, 24);
        cyc("t3_c7", 0, 3'b000, 0, 0, 0,  3'b010, 0, 0, 0);
        cyc("t3_c8", 0, 3'b000, 0, 0, 0,  3'b110, 1, 1, 26);
        cyc("t3_c9", 0, 3'b000, 0, 0, 0,  3'b111, 1, 2, 27);
        cyc("t3_c10", 0, 3'b000, 0, 0, 0, 3'b111, 1, 0, 25);

        // 4: LSU held while ALU streams, pointer starting at ALU
        cyc("t4_b0", 0, 3'b100, 0, 0, 8,  3'b111, 0, 0, 0);
        cyc("t4_b1", 0, 3'b000, 0, 0, 0,  3'b111, 0, 0, 0);
        cyc("t4_b2", 0, 3'b000, 0, 0, 0,  3'b111, 1, 2, 8);
        cyc("t4_d0", 0, 3'b011, 1, 11, 0, 3'b111, 0, 0, 0);
        cyc("t4_d1", 0, 3'b011, 2, 12, 0, 3'b101, 0, 0, 0);
        cyc("t4_d2", 0, 3'b011, 3, 12, 0, 3'b110, 1, 0, 1);
        cyc("t4_d3", 0, 3'b001, 3, 0, 0,  3'b101, 1, 1, 11);
        cyc("t4_d4", 0, 3'b001, 4, 0, 0,  3'b110, 1, 0, 2);
        cyc("t4_d5", 0, 3'b001, 4, 0, 0,  3'b111, 1, 1, 12);
        cyc("t4_d6", 0, 3'b000, 0, 0, 0,  3'b111, 1, 0, 3);
        cyc("t4_d7", 0, 3'b000, 0, 0, 0,  3'b111, 1, 0, 4);
        cyc("t4_d8", 0, 3'b000, 0, 0, 0,  3'b111, 0, 0, 0);

        // 5: flush with three holds full and one packet on the bus
        cyc("t5_f0", 0, 3'b111, 31, 32, 33, 3'b111, 0, 0, 0);
        cyc("t5_f1", 0, 3'b010, 0, 34, 0,   3'b010, 0, 0, 0);
        cyc("t5_f2", 1, 3'b111, 35, 36, 37, 3'b000, 1, 1, 32);
        cyc("t5_f3", 0, 3'b001, 38, 0, 0,   3'b111, 0, 0, 0);
        cyc("t5_f4", 0, 3'b000, 0, 0, 0,    3'b111, 0, 0, 0);
        cyc("t5_f5", 0, 3'b000, 0, 0, 0,    3'b111, 1, 0, 38);
        cyc("t5_f6", 0, 3'b000, 0, 0, 0,    3'b111, 0, 0, 0);

        // 6: BR streams 20 packets back to back; scoreboard checks order
        for (int k = 0; k < 22; k++) begin
            flush = 1'b0;
            if (k < 20) begin
                req_valid  = 3'b100;
                req_pkt[2] = pk(40 + k);
                exp_q.push_back(pk(40 + k));
            end else begin
                req_valid = 3'b000;
            end
            #1;
            if (k < 20) begin
                check($sformatf("t6_s%0d.ready", k), 64'(req_ready), 64'(3'b111));
            end
            if (k >= 2) begin
                check($sformatf("t6_s%0d.cdb_valid", k), 64'(cdb_valid), 64'(1'b1));
                check($sformatf("t6_s%0d.cdb_src", k), 64'(cdb_src), 64'(SRC_BR));
                if (exp_q.size() == 0) begin
                    check($sformatf("t6_s%0d.exp_q_empty", k), 64'(0), 64'(1));
                end else begin
                    exp_pkt = exp_q.pop_front();
                    check($sformatf("t6_s%0d.cdb_pkt", k), 64'(cdb_pkt), 64'(exp_pkt));
                end
            end
            tick();
        end
        #1;
        check("t6_end.cdb_valid", 64'(cdb_valid), 64'(1'b0));
        check("t6_end.exp_q_size", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
